acq_search_ctrl: RTL and testbench

ACQ_SEARCH_CTRL -- requirements
Module: acq_search_ctrl

---
 rtl/acq_search_ctrl_pkg.sv | 41 ++++
 rtl/acq_search_ctrl.sv | 167 ++++++++++++++++
 tb/tb_acq_search_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_search_ctrl_pkg.sv
// Shared GPS acquisition definitions: C/A code length, default carrier NCO
// tuning, search FSM state encoding and the hypothesis/best-peak payloads.
package acq_search_ctrl_pkg;

  localparam int unsigned CODE_LEN = 1023;
  localparam int unsigned PRN_W    = 5;
  localparam int unsigned PHASE_W  = 10;
  localparam int unsigned BIN_W    = 5;
  localparam int unsigned MAG_W    = 24;
  localparam int unsigned TW_W     = 32;

  // Bin 0 tuning word; bin 10 lands on 16 kHz IF at a 16 MHz sample clock.
  localparam logic [TW_W-1:0] TW_BASE_DEFAULT = 32'd2952787;
  // Roughly 500 Hz per Doppler bin.
  localparam logic [TW_W-1:0] TW_STEP_DEFAULT = 32'd134218;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CLEAR  = 3'd2,
    S_INTEG  = 3'd3,
    S_EVAL   = 3'd4,
    S_DONE   = 3'd5
  } acq_state_e;

  // Hypothesis currently driven to the correlator.
  typedef struct packed {
    logic [PRN_W-1:0]   prn;
    logic [PHASE_W-1:0] phase;
    logic [BIN_W-1:0]   bin;
    logic [TW_W-1:0]    tw;
  } acq_hyp_t;

  // Strongest correlation seen so far in the current search.
  typedef struct packed {
    logic [MAG_W-1:0]   mag;
    logic [PHASE_W-1:0] phase;
    logic [BIN_W-1:0]   bin;
  } acq_best_t;

endpackage

// File: rtl/acq_search_ctrl.sv
// GPS acquisition search controller. Steps a correlator through every code
// phase (0..1022) of every Doppler bin for one PRN, waits SETTLE cycles after
// each hypothesis change, clears the correlator, waits for its dump and keeps
// the strongest magnitude (earliest hypothesis wins ties).
//
// Ports:
//   CLK_16M, RST_N          sole clock, asynchronous active-low reset
//   start, abort            search launch pulse / level abort
//   prn_in, threshold       satellite to search, detection level
//   dump_valid, dump_mag    correlator integration result
//   PRN, phase, doppler_tw  current hypothesis to the correlator
//   corr_clr                one-cycle correlator accumulator clear
//   busy, done, detected    status; done is a one-cycle pulse
//   best_phase/bin/mag      strongest hypothesis of the last search
module acq_search_ctrl
  import acq_search_ctrl_pkg::*;
#(
  parameter int unsigned     N_BINS  = 21,
  parameter logic [TW_W-1:0] TW_BASE = TW_BASE_DEFAULT,
  parameter logic [TW_W-1:0] TW_STEP = TW_STEP_DEFAULT,
  parameter int unsigned     SETTLE  = 16
) (
  input  logic               CLK_16M,
  input  logic               RST_N,
  input  logic               start,
  input  logic               abort,
  input  logic [PRN_W-1:0]   prn_in,
  input  logic [MAG_W-1:0]   threshold,
  input  logic               dump_valid,
  input  logic [MAG_W-1:0]   dump_mag,
  output logic [PRN_W-1:0]   PRN,
  output logic [PHASE_W-1:0] phase,
  output logic [TW_W-1:0]    doppler_tw,
  output logic               corr_clr,
  output logic               busy,
  output logic               done,
  output logic               detected,
  output logic [PHASE_W-1:0] best_phase,
  output logic [BIN_W-1:0]   best_bin,
  output logic [MAG_W-1:0]   best_mag
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(CODE_LEN - 1);
  localparam logic [BIN_W-1:0]   BIN_LAST    = BIN_W'(N_BINS - 1);

  acq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  acq_hyp_t         hyp_q, hyp_d;
  acq_best_t        best_q, best_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic             detected_q, detected_d;
  logic             corr_clr_q, corr_clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and output registers.
  always_ff @(posedge CLK_16M or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hyp_q      <= '{prn: '0, phase: '0, bin: '0, tw: TW_BASE};
      best_q     <= '0;
      mag_q      <= '0;
      detected_q <= 1'b0;
      corr_clr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hyp_q      <= hyp_d;
      best_q     <= best_d;
      mag_q      <= mag_d;
      detected_q <= detected_d;
      corr_clr_q <= corr_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, hypothesis stepping and peak tracking.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    hyp_d      = hyp_q;
    best_d     = best_q;
    mag_d      = mag_q;
    detected_d = detected_q;
    corr_clr_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETTLE;
          hyp_d      = '{prn: prn_in, phase: '0, bin: '0, tw: TW_BASE};
          best_d     = '0;
          detected_d = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_CLEAR;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_CLEAR: state_d = S_INTEG;
      S_INTEG: begin
        if (dump_valid) begin
          mag_d   = dump_mag;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        // Strict compare so a tie keeps the earlier hypothesis.
        if (mag_q > best_q.mag) begin
          best_d.mag   = mag_q;
          best_d.phase = hyp_q.phase;
          best_d.bin   = hyp_q.bin;
        end
        if (hyp_q.phase != PHASE_LAST) begin
          hyp_d.phase = hyp_q.phase + PHASE_W'(1);
          state_d     = S_SETTLE;
        end else if (hyp_q.bin != BIN_LAST) begin
          hyp_d.phase = '0;
          hyp_d.bin   = hyp_q.bin + BIN_W'(1);
          hyp_d.tw    = hyp_q.tw + TW_STEP;
          state_d     = S_SETTLE;
        end else begin
          // Last hypothesis: decide on the peak including this dump.
          state_d    = S_DONE;
          detected_d = (best_d.mag >= threshold);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort freezes hypothesis and results where they are.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      hyp_d      = hyp_q;
      best_d     = best_q;
      mag_d      = mag_q;
      detected_d = detected_q;
    end

    // Status flops mirror the state being entered so they align with it.
    corr_clr_d = (state_d == S_CLEAR);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  assign PRN        = hyp_q.prn;
  assign phase      = hyp_q.phase;
  assign doppler_tw = hyp_q.tw;
  assign corr_clr   = corr_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign detected   = detected_q;
  assign best_phase = best_q.phase;
  assign best_bin   = best_q.bin;
  assign best_mag   = best_q.mag;

endmodule

// File: tb/tb_acq_search_ctrl.sv
// Bench for acq_search_ctrl: correlator model answering 5 cycles after each
// clear, a search-level reference model, per-cycle compare, directed tests.
module tb_acq_search_ctrl;

  localparam int          N_BINS  = 3;
  localparam int          SETTLE  = 2;
  localparam int          TOTAL   = N_BINS * 1023;
  localparam logic [31:0] TW_BASE = 32'd2952787;
  localparam logic [31:0] TW_STEP = 32'd134218;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start, abort;
  logic [4:0]  prn_in;
  logic [23:0] threshold;
  logic        dump_valid;
  logic [23:0] dump_mag;
  logic [4:0]  PRN;
  logic [9:0]  phase;
  logic [31:0] doppler_tw;
  logic        corr_clr, busy, done, detected;
  logic [9:0]  best_phase;
  logic [4:0]  best_bin;
  logic [23:0] best_mag;

  logic        corr_dv = 1'b0;
  logic [23:0] corr_mag = 24'h0;
  logic        stray_dv = 1'b0;
  int          tcase = 0;

  int n_checks = 0;
  int n_err    = 0;
  int clr_cnt  = 0;
  int done_cnt = 0;
  logic [31:0] peak_tw = 32'h0;

  assign dump_valid = corr_dv | stray_dv;
  assign dump_mag   = stray_dv ? 24'hFFFFFF : corr_mag;

  acq_search_ctrl #(.N_BINS(N_BINS), .SETTLE(SETTLE)) dut (
    .CLK_16M(clk), .RST_N(rst_n), .start(start), .abort(abort),
    .prn_in(prn_in), .threshold(threshold),
    .dump_valid(dump_valid), .dump_mag(dump_mag),
    .PRN(PRN), .phase(phase), .doppler_tw(doppler_tw), .corr_clr(corr_clr),
    .busy(busy), .done(done), .detected(detected),
    .best_phase(best_phase), .best_bin(best_bin), .best_mag(best_mag)
  );

  always #5 clk = ~clk;

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      if (n_err >= 50) begin
        summary();
        $finish;
      end
    end
  endtask

  // Correlation magnitude of hypothesis (phase, bin) for the current scenario.
  function automatic logic [23:0] mag_of(input int ph, input int bn);
    case (tcase)
      0:       return (ph == 4 && bn == 2) ? 24'd900 : 24'd100;
      1:       return (ph == 7 && bn <= 1) ? 24'd300 : 24'd50;
      default: return 24'((ph * 37 + bn * 11) % 1000);
    endcase
  endfunction

  // Correlator: dump sampled by the DUT 5 edges after the clear edge.
  int          cl_cnt = 0;
  logic [23:0] cl_mag = 24'h0;
  always @(negedge clk) begin : corr_model
    int cl_bin;
    if (corr_clr === 1'b1) begin
      cl_bin = int'((doppler_tw - TW_BASE) / TW_STEP);
      cl_mag = mag_of(int'(phase), cl_bin);
      if (phase == 10'd4 && cl_bin == 2) peak_tw = doppler_tw;
      cl_cnt = 5;
    end else if (cl_cnt > 0) begin
      cl_cnt = cl_cnt - 1;
    end
    corr_dv  = (cl_cnt == 1);
    corr_mag = corr_dv ? cl_mag : 24'hABCDEF;
  end

  // Reference model of a search: hypotheses in order, clears spaced by
  // settle + correlator latency, running maximum, done after the last one.
  bit          m_busy = 1'b0, m_fin = 1'b0;
  int          m_hyp = 0, m_ncl = 0, m_since = 0;
  logic [4:0]  m_prn = 5'd0, m_bbin = 5'd0;
  logic [9:0]  m_bph = 10'd0;
  logic [23:0] m_bmag = 24'd0;
  logic        m_det = 1'b0, e_clr = 1'b0, e_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin : ref_model
    int ph, bn;
    logic [23:0] mg;
    if (!rst_n) begin
      m_busy = 1'b0; m_fin = 1'b0; m_hyp = 0; m_ncl = 0; m_since = 0;
      m_prn = 5'd0; m_bmag = 24'd0; m_bph = 10'd0; m_bbin = 5'd0; m_det = 1'b0;
      e_clr = 1'b0; e_done = 1'b0;
    end else begin
      e_clr  = 1'b0;
      e_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_fin = 1'b0; m_prn = prn_in; m_hyp = 0; m_ncl = 0; m_since = 0;
          m_bmag = 24'd0; m_bph = 10'd0; m_bbin = 5'd0; m_det = 1'b0;
        end
      end else if (abort || m_fin) begin
        m_busy = 1'b0;
        m_fin  = 1'b0;
      end else begin
        m_since = m_since + 1;
        if (m_ncl > 0 && m_since == 6) begin
          ph = m_hyp % 1023;
          bn = m_hyp / 1023;
          mg = mag_of(ph, bn);
          if (mg > m_bmag) begin
            m_bmag = mg; m_bph = 10'(ph); m_bbin = 5'(bn);
          end
          if (m_ncl < TOTAL) m_hyp = m_hyp + 1;
          else begin
            m_fin = 1'b1; e_done = 1'b1; m_det = (m_bmag >= threshold);
          end
        end
        if ((m_ncl == 0 && m_since == SETTLE) ||
            (m_ncl > 0 && m_ncl < TOTAL && m_since == SETTLE + 6)) begin
          e_clr = 1'b1; m_ncl = m_ncl + 1; m_since = 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    int e_bin;
    e_bin = m_hyp / 1023;
    chk("busy",       32'(busy),       32'(m_busy));
    chk("done",       32'(done),       32'(e_done));
    chk("corr_clr",   32'(corr_clr),   32'(e_clr));
    chk("PRN",        32'(PRN),        32'(m_prn));
    chk("phase",      32'(phase),      32'(m_hyp % 1023));
    chk("doppler_tw", doppler_tw,      TW_BASE + 32'(e_bin) * TW_STEP);
    chk("best_mag",   32'(best_mag),   32'(m_bmag));
    chk("best_phase", 32'(best_phase), 32'(m_bph));
    chk("best_bin",   32'(best_bin),   32'(m_bbin));
    chk("detected",   32'(detected),   32'(m_det));
    if (corr_clr === 1'b1) clr_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_clr(input int target, input int budget);
    int k;
    k = 0;
    while (clr_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("clr_reached", 32'(clr_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("done_reached", 32'(done_cnt != d0), 32'd1);
  endtask

  initial begin : watchdog
    #900000;
    n_err++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    summary();
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, c0;
    start = 1'b0; abort = 1'b0; prn_in = 5'd0; threshold = 24'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tw",   doppler_tw, 32'd2952787);
    chk("rst_best", 32'(best_mag), 32'd0);

    // Stray dump while idle must be ignored.
    @(posedge clk); #2 stray_dv = 1'b1;
    @(posedge clk); #2 stray_dv = 1'b0;

    // Single peak at (phase 4, bin 2), above threshold.
    tcase = 0; threshold = 24'd500; prn_in = 5'd12;
    d0 = done_cnt; c0 = clr_cnt;
    pulse_start();
    wait_done(d0, 30000);
    repeat (20) @(posedge clk);
    #2;
    chk("peak_done_once", 32'(done_cnt - d0), 32'd1);
    chk("peak_clr_total", 32'(clr_cnt - c0), 32'd3069);
    chk("peak_phase",     32'(best_phase), 32'd4);
    chk("peak_bin",       32'(best_bin),   32'd2);
    chk("peak_mag",       32'(best_mag),   32'd900);
    chk("peak_detected",  32'(detected),   32'd1);
    chk("peak_tw",        peak_tw,         32'd3221223);
    chk("peak_idle",      32'(busy),       32'd0);
    chk("peak_prn",       32'(PRN),        32'd12);

    // Equal peaks in bins 0 and 1 below threshold: earlier one kept.
    tcase = 1; threshold = 24'd400; prn_in = 5'd7;
    d0 = done_cnt; c0 = clr_cnt;
    pulse_start();
    wait_done(d0, 30000);
    repeat (20) @(posedge clk);
    #2;
    chk("tie_done_once", 32'(done_cnt - d0), 32'd1);
    chk("tie_clr_total", 32'(clr_cnt - c0), 32'd3069);
    chk("tie_phase",     32'(best_phase), 32'd7);
    chk("tie_bin",       32'(best_bin),   32'd0);
    chk("tie_mag",       32'(best_mag),   32'd300);
    chk("tie_detected",  32'(detected),   32'd0);

    // Abort during integration of hypothesis 500.
    tcase = 2; threshold = 24'd0; prn_in = 5'd3;
    d0 = done_cnt; c0 = clr_cnt;
    pulse_start();
    wait_clr(c0 + 501, 6000);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_phase", 32'(phase), 32'd500);
    repeat (20) @(posedge clk);
    #2;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Restart, start-while-busy, stray dump in settle, reset in integration.
    prn_in = 5'd9;
    d0 = done_cnt; c0 = clr_cnt;
    pulse_start();
    wait_clr(c0 + 1, 100);
    #2;
    chk("restart_phase", 32'(phase), 32'd0);
    chk("restart_tw",    doppler_tw, 32'd2952787);
    repeat (4) @(posedge clk);
    #2 begin stray_dv = 1'b1; start = 1'b1; prn_in = 5'd20; end
    @(posedge clk); #2 begin stray_dv = 1'b0; start = 1'b0; end
    chk("busy_start_prn", 32'(PRN), 32'd9);
    wait_clr(c0 + 3, 100);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_tw",    doppler_tw,    32'd2952787);
    chk("mid_rst_phase", 32'(phase),    32'd0);
    chk("mid_rst_prn",   32'(PRN),      32'd0);
    chk("mid_rst_best",  32'(best_mag), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("post_rst_idle",    32'(busy), 32'd0);

    summary();
    $finish;
  end

endmodule
